// File: rtl/ldpc_pkg.sv
// ldpc_pkg
//   Definitions shared by the LDPC front end and the decoder core:
//   default LLR sample width, lanes per decoder input word, the packed
//   word type, and a helper that sizes lane counters.
package ldpc_pkg;

    localparam int LDPC_LLR_W  = 6;
    localparam int LDPC_LANES  = 36;
    localparam int LDPC_WORD_W = LDPC_LLR_W * LDPC_LANES;

    // One decoder input word at the default geometry.
    typedef logic [LDPC_WORD_W-1:0] ldpc_word_t;

    // Width of a counter that indexes 0..lanes-1 (at least one bit).
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/ldpc_out_reg.sv
// ldpc_out_reg
//   One-entry ready/valid register slice with a generic payload.
//   Accepts a new entry whenever it is empty or its current entry is
//   being taken in the same cycle, so back-to-back transfers run at
//   full rate. The payload resets to zero.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_valid_i     upstream entry valid
//   in_ready_o     slice can take an entry this cycle
//   in_payload_i   upstream payload
//   out_valid_o    slice holds an entry
//   out_ready_i    downstream takes the entry
//   out_payload_o  held payload, stable while out_valid_o & !out_ready_i
module ldpc_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_payload_o
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    assign in_ready_o    = !valid_q || out_ready_i;
    assign out_valid_o   = valid_q;
    assign out_payload_o = payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (in_valid_i && in_ready_o) begin
            valid_d   = 1'b1;
            payload_d = in_payload_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/ldpc_llr_packer.sv
// ldpc_llr_packer
//   Collects serial LLR samples into LANES-wide decoder input words with
//   frame delimiting, zero-padded flush of a partial word at end of frame,
//   a per-frame word index and ready/valid backpressure on both sides.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   sample handshake
//   in_llr              sample value (passed through unmodified)
//   in_sof/in_eof       frame delimiters, qualified by accept
//   out_valid/out_ready word handshake
//   out_data            packed word, unfilled lanes zero
//   out_fill            number of valid lanes (1..LANES)
//   out_sof/out_eof     first/last word of the frame
//   out_widx            word index within the frame
//   err_sof             one-cycle pulse: SOF while a frame was still open
module ldpc_llr_packer
    import ldpc_pkg::*;
#(
    parameter int LLR_W     = LDPC_LLR_W,
    parameter int LANES     = LDPC_LANES,
    parameter int LSB_FIRST = 1,
    parameter int WIDX_W    = 16,
    localparam int FILL_W   = $clog2(LANES + 1),
    localparam int WORD_W   = LLR_W * LANES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LLR_W-1:0]  in_llr,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [FILL_W-1:0] out_fill,
    output logic              out_sof,
    output logic              out_eof,
    output logic [WIDX_W-1:0] out_widx,
    output logic              err_sof
);

    localparam int CNT_W = cnt_width(LANES);
    localparam int PAY_W = WORD_W + FILL_W + 2 + WIDX_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    // Word assembly state; pack_q doubles as the holding buffer for a
    // closed word that could not enter the output register (pending_q).
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              open_q, open_d;
    logic              first_q, first_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [FILL_W-1:0] pfill_q, pfill_d;
    logic              psof_q, psof_d;
    logic              peof_q, peof_d;
    logic [WIDX_W-1:0] pwidx_q, pwidx_d;
    logic              err_q, err_d;

    logic              accept;
    logic              out_free;
    logic              ld_valid;
    logic [PAY_W-1:0]  ld_payload;
    logic [PAY_W-1:0]  out_payload;

    logic [WORD_W-1:0] base_pack;
    logic [CNT_W-1:0]  base_cnt;
    logic [CNT_W-1:0]  lane_sel;
    logic [WORD_W-1:0] word;
    logic [FILL_W-1:0] fill;
    logic [WIDX_W-1:0] wr_widx;
    logic              wr_first;

    assign in_ready = !pending_q;
    assign accept   = in_valid && in_ready;
    assign err_sof  = err_q;

    always_comb begin
        pack_d     = pack_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        open_d     = open_q;
        first_d    = first_q;
        widx_d     = widx_q;
        pfill_d    = pfill_q;
        psof_d     = psof_q;
        peof_d     = peof_q;
        pwidx_d    = pwidx_q;
        err_d      = 1'b0;
        ld_valid   = 1'b0;
        ld_payload = '0;
        base_pack  = pack_q;
        base_cnt   = cnt_q;
        lane_sel   = '0;
        word       = '0;
        fill       = '0;
        wr_widx    = widx_q;
        wr_first   = first_q;

        if (pending_q) begin
            // No accepts while pending, so only the drain can happen here.
            if (out_free) begin
                ld_valid   = 1'b1;
                ld_payload = {pack_q, pfill_q, psof_q, peof_q, pwidx_q};
                pack_d     = '0;
                pending_d  = 1'b0;
            end
        end else if (accept && (in_sof || open_q)) begin
            if (in_sof) begin
                // A new SOF throws away any partial word of the open frame.
                base_pack = '0;
                base_cnt  = '0;
                wr_widx   = '0;
                wr_first  = 1'b1;
                open_d    = 1'b1;
                err_d     = open_q;
            end

            lane_sel = (LSB_FIRST != 0) ? base_cnt : (LAST - base_cnt);
            // Lanes above cnt are always zero, so OR-ing places the sample.
            word     = base_pack | (WORD_W'(in_llr) << (int'(lane_sel) * LLR_W));

            if (base_cnt == LAST || in_eof) begin
                fill    = FILL_W'(base_cnt) + FILL_W'(1);
                cnt_d   = '0;
                widx_d  = wr_widx + WIDX_W'(1);
                first_d = 1'b0;
                if (in_eof) begin
                    open_d = 1'b0;
                end
                if (out_free) begin
                    ld_valid   = 1'b1;
                    ld_payload = {word, fill, wr_first, in_eof, wr_widx};
                    pack_d     = '0;
                end else begin
                    pending_d = 1'b1;
                    pack_d    = word;
                    pfill_d   = fill;
                    psof_d    = wr_first;
                    peof_d    = in_eof;
                    pwidx_d   = wr_widx;
                end
            end else begin
                pack_d  = word;
                cnt_d   = base_cnt + CNT_W'(1);
                widx_d  = wr_widx;
                first_d = wr_first;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_q    <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            open_q    <= 1'b0;
            first_q   <= 1'b0;
            widx_q    <= '0;
            pfill_q   <= '0;
            psof_q    <= 1'b0;
            peof_q    <= 1'b0;
            pwidx_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pack_q    <= pack_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            open_q    <= open_d;
            first_q   <= first_d;
            widx_q    <= widx_d;
            pfill_q   <= pfill_d;
            psof_q    <= psof_d;
            peof_q    <= peof_d;
            pwidx_q   <= pwidx_d;
            err_q     <= err_d;
        end
    end

    ldpc_out_reg #(
        .PAYLOAD_W(PAY_W)
    ) u_out_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (ld_valid),
        .in_ready_o   (out_free),
        .in_payload_i (ld_payload),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_payload_o(out_payload)
    );

    assign {out_data, out_fill, out_sof, out_eof, out_widx} = out_payload;

endmodule

// File: tb/tb_ldpc_llr_packer.sv
module tb_ldpc_llr_packer;
    import ldpc_pkg::*;

    typedef struct {
        ldpc_word_t data;
        int         fill;
        bit         sof;
        bit         eof;
        int         widx;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_llr = '0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    ldpc_word_t  out_data;
    logic [5:0]  out_fill;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] out_widx;
    logic        err_sof;

    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [5:0]  m_in_llr = '0;
    logic        m_in_sof = 1'b0;
    logic        m_in_eof = 1'b0;
    logic        m_out_valid;
    ldpc_word_t  m_out_data;
    logic [5:0]  m_out_fill;
    logic        m_out_sof;
    logic        m_out_eof;
    logic [15:0] m_out_widx;
    logic        m_err_sof;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ldpc_llr_packer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .in_sof(in_sof), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fill(out_fill), .out_sof(out_sof), .out_eof(out_eof),
        .out_widx(out_widx), .err_sof(err_sof)
    );

    ldpc_llr_packer #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset_n(reset_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_llr(m_in_llr),
        .in_sof(m_in_sof), .in_eof(m_in_eof),
        .out_valid(m_out_valid), .out_ready(1'b1), .out_data(m_out_data),
        .out_fill(m_out_fill), .out_sof(m_out_sof), .out_eof(m_out_eof),
        .out_widx(m_out_widx), .err_sof(m_err_sof)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic int lane_of(input ldpc_word_t w, input int i);
        return int'(w[i*6 +: 6]);
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    word_t exp_q[$];
    word_t cap_q[$];
    int    m_buf[36];
    int    m_cnt = 0;
    bit    m_open = 0;
    int    m_widx = 0;
    bit    exp_err = 0;
    int    err_pulses = 0;
    bit    prev_hold = 0;
    word_t prev_w;

    always @(negedge clk) begin : model
        word_t cur, e, nw;
        if (!reset_n) begin
            exp_q.delete();
            m_cnt = 0; m_open = 0; m_widx = 0; exp_err = 0; prev_hold = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_fill", out_fill, 0);
            chk("rst_out_flags", {out_sof, out_eof, err_sof}, 0);
            chk("rst_out_widx", out_widx, 0);
        end else begin
            chk("err_sof", err_sof, exp_err);
            if (err_sof) err_pulses++;
            exp_err = 0;

            cur.data = out_data; cur.fill = int'(out_fill); cur.sof = out_sof;
            cur.eof = out_eof; cur.widx = int'(out_widx);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", cur.data, prev_w.data);
                chk("hold_meta", {cur.fill, cur.sof, cur.eof, cur.widx},
                    {prev_w.fill, prev_w.sof, prev_w.eof, prev_w.widx});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", cur.data, e.data);
                    chk("word_meta", {cur.fill, cur.sof, cur.eof, cur.widx},
                        {e.fill, e.sof, e.eof, e.widx});
                end
                cap_q.push_back(cur);
            end
            prev_hold = out_valid && !out_ready;
            prev_w = cur;

            if (in_valid && in_ready && (in_sof || m_open)) begin
                if (in_sof) begin
                    if (m_open) exp_err = 1;
                    m_open = 1; m_cnt = 0; m_widx = 0;
                end
                m_buf[m_cnt] = int'(in_llr);
                m_cnt++;
                if (m_cnt == 36 || in_eof) begin
                    nw.data = '0;
                    for (int i = 0; i < m_cnt; i++) nw.data[i*6 +: 6] = 6'(m_buf[i]);
                    nw.fill = m_cnt; nw.sof = (m_widx == 0); nw.eof = in_eof;
                    nw.widx = m_widx;
                    exp_q.push_back(nw);
                    m_widx++; m_cnt = 0;
                    if (in_eof) m_open = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int v, input bit s, input bit e);
        int n;
        n = 0;
        in_valid = 1; in_llr = 6'(v); in_sof = s; in_eof = e;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; in_sof = 0; in_eof = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int e0;
        ldpc_word_t held;
        ldpc_word_t m_exp;

        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        idle(2);

        // 1: 72 samples, two full words, out_ready=1
        c0 = cap_q.size();
        for (int i = 0; i < 72; i++) send(i % 64, i == 0, i == 71);
        @(negedge clk);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_latency_eof", out_eof, 1);
        chk("t1_latency_widx", out_widx, 1);
        idle(3);
        chk("t1_words", cap_q.size() - c0, 2);
        chk("t1_w0_lane0", lane_of(cap_q[c0].data, 0), 0);
        chk("t1_w0_lane35", lane_of(cap_q[c0].data, 35), 35);
        chk("t1_w0_meta", {cap_q[c0].sof, cap_q[c0].eof, cap_q[c0].widx, cap_q[c0].fill},
            {1'b1, 1'b0, 32'd0, 32'd36});
        chk("t1_w1_lane0", lane_of(cap_q[c0+1].data, 0), 36);
        chk("t1_w1_lane35", lane_of(cap_q[c0+1].data, 35), 7);
        chk("t1_w1_meta", {cap_q[c0+1].sof, cap_q[c0+1].eof, cap_q[c0+1].widx},
            {1'b0, 1'b1, 32'd1});

        // 2: 40-sample frame, zero-padded tail word
        c0 = cap_q.size();
        for (int i = 0; i < 40; i++) send((i * 3) % 64, i == 0, i == 39);
        idle(3);
        chk("t2_words", cap_q.size() - c0, 2);
        chk("t2_w0_fill", cap_q[c0].fill, 36);
        chk("t2_w1_fill", cap_q[c0+1].fill, 4);
        chk("t2_w1_eof", cap_q[c0+1].eof, 1);
        chk("t2_w1_lane3", lane_of(cap_q[c0+1].data, 3), 53);
        chk("t2_w1_tail_zero", cap_q[c0+1].data >> 24, 0);

        // 3: backpressure across two full words
        c0 = cap_q.size();
        out_ready = 0;
        for (int i = 0; i < 72; i++) send((i + 5) % 64, i == 0, i == 71);
        @(negedge clk);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        held = out_data;
        idle(4);
        chk("t3_data_stable", out_data, held);
        chk("t3_no_words_yet", cap_q.size() - c0, 0);
        out_ready = 1;
        @(negedge clk);
        chk("t3_in_ready_still_low", in_ready, 0);
        @(negedge clk);
        chk("t3_in_ready_back", in_ready, 1);
        idle(3);
        chk("t3_words", cap_q.size() - c0, 2);
        chk("t3_order", {cap_q[c0].widx, cap_q[c0+1].widx}, {32'd0, 32'd1});
        chk("t3_w0_lane0", lane_of(cap_q[c0].data, 0), 5);

        // 4: SOF re-sync inside an open frame
        c0 = cap_q.size();
        e0 = err_pulses;
        for (int i = 0; i < 10; i++) send(i + 1, i == 0, 0);
        for (int i = 0; i < 36; i++) send(20 + i, i == 0, i == 35);
        idle(3);
        chk("t4_err_pulses", err_pulses - e0, 1);
        chk("t4_words", cap_q.size() - c0, 1);
        chk("t4_meta", {cap_q[c0].sof, cap_q[c0].eof, cap_q[c0].widx, cap_q[c0].fill},
            {1'b1, 1'b1, 32'd0, 32'd36});
        chk("t4_lane0", lane_of(cap_q[c0].data, 0), 20);

        // 5: samples outside a frame are dropped; MSB-first single-sample frame
        c0 = cap_q.size();
        for (int i = 0; i < 3; i++) send(9, 0, 0);
        idle(3);
        chk("t5_dropped", cap_q.size() - c0, 0);
        m_in_valid = 1; m_in_llr = 6'd5; m_in_sof = 0; m_in_eof = 0;
        @(posedge clk); #1;
        m_in_llr = 6'h2A; m_in_sof = 1; m_in_eof = 1;
        @(negedge clk);
        chk("t5_msb_drop", m_out_valid, 0);
        @(posedge clk); #1;
        m_in_valid = 0; m_in_sof = 0; m_in_eof = 0;
        @(negedge clk);
        m_exp = '0;
        m_exp[215:210] = 6'h2A;
        chk("t5_msb_valid", m_out_valid, 1);
        chk("t5_msb_data", m_out_data, m_exp);
        chk("t5_msb_meta", {m_out_fill, m_out_sof, m_out_eof, m_out_widx},
            {6'd1, 1'b1, 1'b1, 16'd0});
        idle(2);

        // 6: reset mid-word
        for (int i = 0; i < 6; i++) send(50 + i, i == 0, 0);
        reset_n = 0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        idle(2);
        reset_n = 1;
        idle(1);
        c0 = cap_q.size();
        for (int i = 0; i < 36; i++) send(40 + i, i == 0, i == 35);
        idle(3);
        chk("t6_words", cap_q.size() - c0, 1);
        chk("t6_lane0", lane_of(cap_q[c0].data, 0), 40);
        chk("t6_meta", {cap_q[c0].fill, cap_q[c0].widx, cap_q[c0].sof}, {32'd36, 32'd0, 1'b1});

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
